// File: rtl/cb_alloc_dispatch_if.sv
// Signal bundle between decode, the completion buffer, issue and cb_alloc_dispatch.
// The slave modport is the dispatch block's view; master is the surrounding pipeline's view.
interface cb_alloc_dispatch_if #(parameter int NUM_ENTRY = 16);
  localparam int IW = $clog2(NUM_ENTRY);

  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_fu_sel;
  logic [4:0]    in_vd;
  logic          in_wen;
  logic [31:0]   in_pc;
  logic          in_rv32v;
  logic          in_rv32v_wb_scalar;

  logic [IW-1:0] cb_cur_tail;
  logic          cb_full;
  logic          cb_flush;
  logic          cb_alloc_ena;
  logic          cb_rv32v_instr;
  logic          cb_rv32v_wb_scalar_ena;

  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic [1:0]    out_fu_sel;
  logic [4:0]    out_vd;
  logic          out_wen;
  logic [31:0]   out_pc;
  logic          out_rv32v;

  logic          alloc_err;

  modport slave (
    input  in_valid, in_fu_sel, in_vd, in_wen, in_pc, in_rv32v, in_rv32v_wb_scalar,
    input  cb_cur_tail, cb_full, cb_flush, out_ready,
    output in_ready, cb_alloc_ena, cb_rv32v_instr, cb_rv32v_wb_scalar_ena,
    output out_valid, out_index, out_fu_sel, out_vd, out_wen, out_pc, out_rv32v, alloc_err
  );

  modport master (
    output in_valid, in_fu_sel, in_vd, in_wen, in_pc, in_rv32v, in_rv32v_wb_scalar,
    output cb_cur_tail, cb_full, cb_flush, out_ready,
    input  in_ready, cb_alloc_ena, cb_rv32v_instr, cb_rv32v_wb_scalar_ena,
    input  out_valid, out_index, out_fu_sel, out_vd, out_wen, out_pc, out_rv32v, alloc_err
  );
endinterface

// File: rtl/cb_alloc_dispatch.sv
// Allocates one completion-buffer entry per decoded instruction and queues it, tagged with the CB tail, for issue.
// Optional tag-consistency checker enabled by defining CB_ALLOC_CHECK_EN (alloc_err tied low otherwise).
module cb_alloc_dispatch #(
  parameter int NUM_ENTRY = 16,
  parameter int QDEPTH    = 4
) (
  input logic CLK,
  input logic nRST,
  cb_alloc_dispatch_if.slave bus
);
  localparam int IW = $clog2(NUM_ENTRY);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(QDEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic {RUN, RECOVER} state_t;

  typedef struct packed {
    logic [IW-1:0] index;
    logic [1:0]    fu_sel;
    logic [4:0]    vd;
    logic          wen;
    logic [31:0]   pc;
    logic          rv32v;
  } entry_t;

  state_t        state;
  entry_t        fifo [QDEPTH];
  entry_t        push_entry;
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          run;
  logic          push;
  logic          pop;

  // No pop bypass: a full FIFO refuses new work even when the head leaves this cycle.
  assign run          = (state == RUN);
  assign bus.in_ready = nRST & run & ~bus.cb_full & ~bus.cb_flush & (count < CNT_MAX);
  assign push         = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (count != '0) & run & ~bus.cb_flush;
  assign pop          = bus.out_valid & bus.out_ready;

  assign bus.cb_alloc_ena           = push;
  assign bus.cb_rv32v_instr         = push & bus.in_rv32v;
  assign bus.cb_rv32v_wb_scalar_ena = push & bus.in_rv32v & bus.in_rv32v_wb_scalar;

  assign push_entry.index  = bus.cb_cur_tail;
  assign push_entry.fu_sel = bus.in_fu_sel;
  assign push_entry.vd     = bus.in_vd;
  assign push_entry.wen    = bus.in_wen;
  assign push_entry.pc     = bus.in_pc;
  assign push_entry.rv32v  = bus.in_rv32v;

  assign head           = fifo[rd_ptr];
  assign bus.out_index  = head.index;
  assign bus.out_fu_sel = head.fu_sel;
  assign bus.out_vd     = head.vd;
  assign bus.out_wen    = head.wen;
  assign bus.out_pc     = head.pc;
  assign bus.out_rv32v  = head.rv32v;

  // Flush wins over everything and empties the queue; RECOVER gives the CB one cycle to rewind its tail.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        fifo[i] <= '0;
      end
    end else if (bus.cb_flush) begin
      state  <= RECOVER;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (push) begin
            fifo[wr_ptr] <= push_entry;
            wr_ptr       <= wr_ptr + PTR_ONE;
          end
          if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
          end
          if (push && !pop) begin
            count <= count + CNT_ONE;
          end else if (pop && !push) begin
            count <= count - CNT_ONE;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef CB_ALLOC_CHECK_EN
  logic [IW:0] shadow_tail;
  logic        alloc_err_q;

  // Independent tail model: any disagreement with the CB's tail on allocation latches an error.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      shadow_tail <= '0;
      alloc_err_q <= 1'b0;
    end else if (bus.cb_flush) begin
      shadow_tail <= '0;
    end else if (push) begin
      shadow_tail <= shadow_tail + (IW+1)'(1);
      if (bus.cb_cur_tail != shadow_tail[IW-1:0]) begin
        alloc_err_q <= 1'b1;
      end
    end
  end

  assign bus.alloc_err = alloc_err_q;
`else
  assign bus.alloc_err = 1'b0;
`endif
endmodule
